decode_64b_67b: RTL and testbench

Receive-side 64B/67B decoder that consumes the 80-bit words produced by the transmit-side 64B/67B encoder after the lane gearbox. It removes the inversion bit, restores the 64-bit payload, checks the 2-bit sync header, and runs the Interlaken block-lock state machine, requesting bit slips from the upstream gearbox until headers align. It sits between the RX gearbox and the lane descrambler/framing logic.

---
 rtl/decode_64b_67b_pkg.sv | 45 ++++
 rtl/block_lock_fsm_67b.sv | 188 ++++++++++++++++++
 rtl/decode_64b_67b.sv | 152 +++++++++++++++
 tb/tb_decode_64b_67b.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_64b_67b_pkg.sv
// ---------------------------------------------------------------------------
// decode_64b_67b_pkg
// Shared definitions for the 64B/67B lane encoder and decoder:
//   - block-lock FSM state encoding
//   - sync header values (data / control)
//   - bit positions inside the 80-bit gearbox word
//   - small header/payload helper functions
// ---------------------------------------------------------------------------
package decode_64b_67b_pkg;

    // Block-lock state machine states
    typedef enum logic [1:0] {
        ST_HUNT   = 2'b00,
        ST_WAIT   = 2'b01,
        ST_LOCKED = 2'b10
    } lock_state_e;

    // Sync header values; 2'b00 and 2'b11 never appear on a healthy lane
    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    // Field positions in the 80-bit word delivered by the RX gearbox
    localparam int WORD_W    = 80;
    localparam int PAYLOAD_W = 64;
    localparam int INV_BIT   = 66;
    localparam int SH_MSB    = 65;
    localparam int SH_LSB    = 64;
    localparam int PAD_LSB   = 67;

    // A header is legal exactly when its two bits differ
    function automatic logic sh_is_valid(input logic [1:0] sh);
        return sh[1] ^ sh[0];
    endfunction

    // Undo the transmit-side disparity inversion of the payload
    function automatic logic [PAYLOAD_W-1:0] restore_payload(
        input logic                 inv,
        input logic [PAYLOAD_W-1:0] payload
    );
        logic [PAYLOAD_W-1:0] mask;
        mask = {PAYLOAD_W{inv}};
        return payload ^ mask;
    endfunction

endpackage : decode_64b_67b_pkg

// File: rtl/block_lock_fsm_67b.sv
// ---------------------------------------------------------------------------
// block_lock_fsm_67b
// Interlaken-style block-lock state machine. Hunts for LOCK_COUNT consecutive
// valid sync headers, then watches WINDOW-word windows and drops lock when
// ERR_LIMIT invalid headers land in one window. Every exit to WAIT raises a
// one-cycle SLIP request to the gearbox, after which SLIP_WAIT cycles are
// ignored while the gearbox re-aligns.
//
// Ports:
//   USER_CLK      clock
//   SYSTEM_RESET  asynchronous active-high reset
//   PASSTHROUGH   forces HUNT with all counters cleared
//   word_valid    a word is present this cycle
//   header_valid  the present word carries a legal sync header
//   BLOCK_LOCK    registered: FSM is in LOCKED
//   SLIP          registered one-cycle slip request
//   in_wait       registered: FSM is in WAIT (input is being ignored)
// ---------------------------------------------------------------------------
module block_lock_fsm_67b
    import decode_64b_67b_pkg::*;
#(
    parameter int LOCK_COUNT = 64,
    parameter int WINDOW     = 64,
    parameter int ERR_LIMIT  = 16,
    parameter int SLIP_WAIT  = 32
) (
    input  logic USER_CLK,
    input  logic SYSTEM_RESET,
    input  logic PASSTHROUGH,
    input  logic word_valid,
    input  logic header_valid,
    output logic BLOCK_LOCK,
    output logic SLIP,
    output logic in_wait
);

    localparam int SH_W   = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W  = $clog2(WINDOW + 1);
    localparam int ERR_W  = $clog2(ERR_LIMIT + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    lock_state_e       state_r;
    lock_state_e       state_nxt_s;
    logic [SH_W-1:0]   sh_cnt_r;
    logic [SH_W-1:0]   sh_cnt_nxt_s;
    logic [SH_W-1:0]   sh_inc_s;
    logic [WIN_W-1:0]  win_cnt_r;
    logic [WIN_W-1:0]  win_cnt_nxt_s;
    logic [WIN_W-1:0]  win_inc_s;
    logic [ERR_W-1:0]  err_cnt_r;
    logic [ERR_W-1:0]  err_cnt_nxt_s;
    logic [ERR_W-1:0]  err_inc_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_nxt_s;
    logic              block_lock_r;
    logic              slip_r;
    logic              in_wait_r;
    logic              lock_s;
    logic              slip_s;
    logic              wait_s;

    // State, counter and registered-output update
    always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
        if (SYSTEM_RESET) begin
            state_r      <= ST_HUNT;
            sh_cnt_r     <= '0;
            win_cnt_r    <= '0;
            err_cnt_r    <= '0;
            wait_cnt_r   <= '0;
            block_lock_r <= 1'b0;
            slip_r       <= 1'b0;
            in_wait_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            sh_cnt_r     <= sh_cnt_nxt_s;
            win_cnt_r    <= win_cnt_nxt_s;
            err_cnt_r    <= err_cnt_nxt_s;
            wait_cnt_r   <= wait_cnt_nxt_s;
            block_lock_r <= lock_s;
            slip_r       <= slip_s;
            in_wait_r    <= wait_s;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_nxt_s    = state_r;
        sh_cnt_nxt_s   = sh_cnt_r;
        win_cnt_nxt_s  = win_cnt_r;
        err_cnt_nxt_s  = err_cnt_r;
        wait_cnt_nxt_s = wait_cnt_r;
        sh_inc_s       = sh_cnt_r + SH_W'(1);
        win_inc_s      = win_cnt_r + WIN_W'(1);
        // The current word's error is folded in before the limit/window tests,
        // so an error on the last word of a window is still counted.
        err_inc_s      = header_valid ? err_cnt_r : (err_cnt_r + ERR_W'(1));

        if (PASSTHROUGH) begin
            state_nxt_s    = ST_HUNT;
            sh_cnt_nxt_s   = '0;
            win_cnt_nxt_s  = '0;
            err_cnt_nxt_s  = '0;
            wait_cnt_nxt_s = '0;
        end else begin
            case (state_r)
                ST_HUNT: begin
                    if (word_valid) begin
                        if (header_valid) begin
                            if (sh_inc_s == SH_W'(LOCK_COUNT)) begin
                                state_nxt_s  = ST_LOCKED;
                                sh_cnt_nxt_s = '0;
                            end else begin
                                sh_cnt_nxt_s = sh_inc_s;
                            end
                        end else begin
                            state_nxt_s    = ST_WAIT;
                            sh_cnt_nxt_s   = '0;
                            wait_cnt_nxt_s = '0;
                        end
                    end else begin
                        state_nxt_s = ST_HUNT;
                    end
                end
                ST_WAIT: begin
                    // Counts clock cycles, not words: the gearbox realigns in time
                    if (wait_cnt_r == WAIT_W'(SLIP_WAIT - 1)) begin
                        state_nxt_s    = ST_HUNT;
                        wait_cnt_nxt_s = '0;
                    end else begin
                        wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (word_valid) begin
                        if (err_inc_s == ERR_W'(ERR_LIMIT)) begin
                            state_nxt_s    = ST_WAIT;
                            win_cnt_nxt_s  = '0;
                            err_cnt_nxt_s  = '0;
                            wait_cnt_nxt_s = '0;
                        end else if (win_inc_s == WIN_W'(WINDOW)) begin
                            win_cnt_nxt_s = '0;
                            err_cnt_nxt_s = '0;
                        end else begin
                            win_cnt_nxt_s = win_inc_s;
                            err_cnt_nxt_s = err_inc_s;
                        end
                    end else begin
                        state_nxt_s = ST_LOCKED;
                    end
                end
                default: begin
                    state_nxt_s    = ST_HUNT;
                    sh_cnt_nxt_s   = '0;
                    win_cnt_nxt_s  = '0;
                    err_cnt_nxt_s  = '0;
                    wait_cnt_nxt_s = '0;
                end
            endcase
        end
    end

    // Outputs derived from the transition; any entry into WAIT is a slip
    always_comb begin
        lock_s = 1'b0;
        slip_s = 1'b0;
        wait_s = 1'b0;
        case (state_nxt_s)
            ST_LOCKED: begin
                lock_s = 1'b1;
            end
            ST_WAIT: begin
                wait_s = 1'b1;
                slip_s = (state_r != ST_WAIT);
            end
            ST_HUNT: begin
                lock_s = 1'b0;
            end
            default: begin
                lock_s = 1'b0;
            end
        endcase
    end

    assign BLOCK_LOCK = block_lock_r;
    assign SLIP       = slip_r;
    assign in_wait    = in_wait_r;

endmodule : block_lock_fsm_67b

// File: rtl/decode_64b_67b.sv
// ---------------------------------------------------------------------------
// decode_64b_67b
// Receive-side 64B/67B decoder. Strips the inversion flag, restores the
// 64-bit payload, reports the sync header, flags and counts invalid headers,
// and drives gearbox bit slips through block_lock_fsm_67b until the lane is
// block-locked.
//
// Ports:
//   USER_CLK        clock
//   SYSTEM_RESET    asynchronous active-high reset
//   PASSTHROUGH     bypass decode and lock logic
//   DATA_IN[79:0]   [66] inversion flag, [65:64] header, [63:0] payload
//   DATA_VALID_IN   DATA_IN carries a word this cycle
//   DATA_OUT[63:0]  decoded payload
//   HEADER_OUT[1:0] received sync header
//   DATA_VALID_OUT  DATA_OUT/HEADER_OUT valid
//   HEADER_ERR      one-cycle pulse: registered word had an invalid header
//   BLOCK_LOCK      lane is block-locked
//   SLIP            one-cycle bit-slip request to the gearbox
//   ERR_COUNT[15:0] saturating invalid-header count
// ---------------------------------------------------------------------------
module decode_64b_67b
    import decode_64b_67b_pkg::*;
#(
    parameter int LOCK_COUNT = 64,
    parameter int WINDOW     = 64,
    parameter int ERR_LIMIT  = 16,
    parameter int SLIP_WAIT  = 32
) (
    input  logic                 USER_CLK,
    input  logic                 SYSTEM_RESET,
    input  logic                 PASSTHROUGH,
    input  logic [WORD_W-1:0]    DATA_IN,
    input  logic                 DATA_VALID_IN,
    output logic [PAYLOAD_W-1:0] DATA_OUT,
    output logic [1:0]           HEADER_OUT,
    output logic                 DATA_VALID_OUT,
    output logic                 HEADER_ERR,
    output logic                 BLOCK_LOCK,
    output logic                 SLIP,
    output logic [15:0]          ERR_COUNT
);

    logic [PAYLOAD_W-1:0] payload_s;
    logic [1:0]           header_s;
    logic                 inv_s;
    logic                 header_valid_s;
    logic                 unused_pad_bits_s;
    logic                 block_lock_s;
    logic                 slip_s;
    logic                 in_wait_s;

    logic [PAYLOAD_W-1:0] data_r;
    logic [PAYLOAD_W-1:0] data_nxt_s;
    logic [1:0]           header_r;
    logic [1:0]           header_nxt_s;
    logic                 valid_r;
    logic                 valid_nxt_s;
    logic                 header_err_r;
    logic                 header_err_nxt_s;
    logic [15:0]          err_count_r;
    logic [15:0]          err_count_nxt_s;

    assign payload_s         = DATA_IN[PAYLOAD_W-1:0];
    assign header_s          = DATA_IN[SH_MSB:SH_LSB];
    assign inv_s             = DATA_IN[INV_BIT];
    assign header_valid_s    = sh_is_valid(header_s);
    // Gearbox pad bits carry nothing; reduced here so they are visibly consumed
    assign unused_pad_bits_s = ^DATA_IN[WORD_W-1:PAD_LSB];

    block_lock_fsm_67b #(
        .LOCK_COUNT (LOCK_COUNT),
        .WINDOW     (WINDOW),
        .ERR_LIMIT  (ERR_LIMIT),
        .SLIP_WAIT  (SLIP_WAIT)
    ) u_block_lock_fsm (
        .USER_CLK     (USER_CLK),
        .SYSTEM_RESET (SYSTEM_RESET),
        .PASSTHROUGH  (PASSTHROUGH),
        .word_valid   (DATA_VALID_IN),
        .header_valid (header_valid_s),
        .BLOCK_LOCK   (block_lock_s),
        .SLIP         (slip_s),
        .in_wait      (in_wait_s)
    );

    // Next values for the decode datapath and error reporting.
    // block_lock_s / in_wait_s are registered FSM flags, i.e. they describe
    // the state in which the current word is being sampled.
    always_comb begin
        data_nxt_s       = data_r;
        header_nxt_s     = header_r;
        valid_nxt_s      = 1'b0;
        header_err_nxt_s = 1'b0;
        if (PASSTHROUGH) begin
            if (DATA_VALID_IN) begin
                data_nxt_s   = payload_s;
                header_nxt_s = header_s;
            end else begin
                data_nxt_s   = data_r;
                header_nxt_s = header_r;
            end
            valid_nxt_s      = DATA_VALID_IN;
            header_err_nxt_s = 1'b0;
        end else begin
            if (DATA_VALID_IN) begin
                data_nxt_s   = restore_payload(inv_s, payload_s);
                header_nxt_s = header_s;
            end else begin
                data_nxt_s   = data_r;
                header_nxt_s = header_r;
            end
            valid_nxt_s      = DATA_VALID_IN & block_lock_s;
            header_err_nxt_s = DATA_VALID_IN & ~header_valid_s & ~in_wait_s;
        end
    end

    // Saturating invalid-header counter; only reset clears it
    always_comb begin
        if (header_err_nxt_s && (err_count_r != 16'hFFFF)) begin
            err_count_nxt_s = err_count_r + 16'd1;
        end else begin
            err_count_nxt_s = err_count_r;
        end
    end

    // Output registers
    always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
        if (SYSTEM_RESET) begin
            data_r       <= '0;
            header_r     <= 2'b00;
            valid_r      <= 1'b0;
            header_err_r <= 1'b0;
            err_count_r  <= 16'd0;
        end else begin
            data_r       <= data_nxt_s;
            header_r     <= header_nxt_s;
            valid_r      <= valid_nxt_s;
            header_err_r <= header_err_nxt_s;
            err_count_r  <= err_count_nxt_s;
        end
    end

    assign DATA_OUT       = data_r;
    assign HEADER_OUT     = header_r;
    assign DATA_VALID_OUT = valid_r;
    assign HEADER_ERR     = header_err_r;
    assign BLOCK_LOCK     = block_lock_s;
    assign SLIP           = slip_s;
    assign ERR_COUNT      = err_count_r;

endmodule : decode_64b_67b

// File: tb/tb_decode_64b_67b.sv
// ---------------------------------------------------------------------------
// tb_decode_64b_67b
// Scoreboard bench: every driven cycle pushes the expected registered outputs
// into a queue; a monitor pops and compares one entry per clock. Directed
// spot checks with hand-computed constants cover the key events.
// ---------------------------------------------------------------------------
module tb_decode_64b_67b;

    logic        USER_CLK = 1'b0;
    logic        SYSTEM_RESET;
    logic        PASSTHROUGH;
    logic [79:0] DATA_IN;
    logic        DATA_VALID_IN;
    logic [63:0] DATA_OUT;
    logic [1:0]  HEADER_OUT;
    logic        DATA_VALID_OUT;
    logic        HEADER_ERR;
    logic        BLOCK_LOCK;
    logic        SLIP;
    logic [15:0] ERR_COUNT;

    always #5 USER_CLK = ~USER_CLK;

    decode_64b_67b dut (
        .USER_CLK       (USER_CLK),
        .SYSTEM_RESET   (SYSTEM_RESET),
        .PASSTHROUGH    (PASSTHROUGH),
        .DATA_IN        (DATA_IN),
        .DATA_VALID_IN  (DATA_VALID_IN),
        .DATA_OUT       (DATA_OUT),
        .HEADER_OUT     (HEADER_OUT),
        .DATA_VALID_OUT (DATA_VALID_OUT),
        .HEADER_ERR     (HEADER_ERR),
        .BLOCK_LOCK     (BLOCK_LOCK),
        .SLIP           (SLIP),
        .ERR_COUNT      (ERR_COUNT)
    );

    typedef struct {
        logic        dv;
        logic [63:0] data;
        logic [1:0]  hdr;
        logic        herr;
        logic        lock;
        logic        slip;
        logic [15:0] ec;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state (0 = hunt, 1 = wait, 2 = locked)
    int          m_state, m_sh, m_win, m_err, m_wait;
    logic [15:0] m_ec;
    logic [63:0] m_data;
    logic [1:0]  m_hdr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic m_reset();
        m_state = 0; m_sh = 0; m_win = 0; m_err = 0; m_wait = 0;
        m_ec = 16'd0; m_data = 64'd0; m_hdr = 2'b00;
    endtask

    function automatic logic [63:0] pl(input int i);
        logic [31:0] x;
        x = i;
        return {x ^ 32'hA5A5_0000, ~x};
    endfunction

    // Drive one cycle at the falling edge and push the expected outputs
    task automatic send(input logic v, input logic inv, input logic [1:0] hdr, input logic [63:0] p);
        exp_t e;
        logic hv;
        @(negedge USER_CLK);
        DATA_VALID_IN = v;
        DATA_IN       = {13'h0F0F, inv, hdr, p};
        hv     = (hdr == 2'b01) || (hdr == 2'b10);
        e.dv   = 1'b0;
        e.herr = 1'b0;
        e.slip = 1'b0;
        if (PASSTHROUGH) begin
            m_state = 0; m_sh = 0; m_win = 0; m_err = 0; m_wait = 0;
            e.dv = v;
            if (v) begin m_data = p; m_hdr = hdr; end
        end else begin
            if (v) begin m_data = inv ? ~p : p; m_hdr = hdr; end
            if (m_state == 0) begin
                if (v && hv) begin
                    m_sh++;
                    if (m_sh == 64) begin m_state = 2; m_sh = 0; end
                end else if (v) begin
                    e.herr = 1'b1; e.slip = 1'b1; m_sh = 0; m_state = 1; m_wait = 0;
                end
            end else if (m_state == 1) begin
                m_wait++;
                if (m_wait == 32) begin m_state = 0; m_wait = 0; end
            end else if (v) begin
                e.dv = 1'b1;
                m_win++;
                if (!hv) begin e.herr = 1'b1; m_err++; end
                if (m_err == 16) begin
                    e.slip = 1'b1; m_state = 1; m_wait = 0; m_win = 0; m_err = 0;
                end else if (m_win == 64) begin
                    m_win = 0; m_err = 0;
                end
            end
        end
        if (e.herr && m_ec != 16'hFFFF) m_ec++;
        e.lock = (m_state == 2);
        e.data = m_data;
        e.hdr  = m_hdr;
        e.ec   = m_ec;
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge USER_CLK);
        #3;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, DATA_OUT, 64'd0);
        check({tag, "_hdr"},  HEADER_OUT, 64'd0);
        check({tag, "_dv"},   DATA_VALID_OUT, 64'd0);
        check({tag, "_herr"}, HEADER_ERR, 64'd0);
        check({tag, "_lock"}, BLOCK_LOCK, 64'd0);
        check({tag, "_slip"}, SLIP, 64'd0);
        check({tag, "_ec"},   ERR_COUNT, 64'd0);
    endtask

    // Monitor: one expected entry per clock, sampled just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge USER_CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_lock", BLOCK_LOCK, e.lock);
                check("sb_slip", SLIP, e.slip);
                check("sb_herr", HEADER_ERR, e.herr);
                check("sb_ec", ERR_COUNT, e.ec);
                check("sb_dv", DATA_VALID_OUT, e.dv);
                if (e.dv) begin
                    check("sb_data", DATA_OUT, e.data);
                    check("sb_hdr", HEADER_OUT, e.hdr);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #400000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: actual=running required=finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Stimulus
    initial begin
        SYSTEM_RESET  = 1'b1;
        PASSTHROUGH   = 1'b0;
        DATA_VALID_IN = 1'b0;
        DATA_IN       = 80'd0;
        m_reset();
        repeat (2) @(posedge USER_CLK);
        #3;
        check_all_zero("reset");
        @(negedge USER_CLK);
        SYSTEM_RESET = 1'b0;

        // HUNT: invalid header slips, then 32 cycles are ignored
        send(1'b1, 1'b0, 2'b11, pl(1));
        settle();
        check("hunt_herr", HEADER_ERR, 64'd1);
        check("hunt_slip", SLIP, 64'd1);
        check("hunt_ec", ERR_COUNT, 64'd1);
        for (int i = 0; i < 32; i++) begin
            send(1'b1, 1'b0, 2'b00, pl(i));
            settle();
            check("wait_noslip", SLIP, 64'd0);
            check("wait_ec", ERR_COUNT, 64'd1);
        end
        send(1'b1, 1'b0, 2'b00, pl(77));
        settle();
        check("reslip", SLIP, 64'd1);
        check("reslip_ec", ERR_COUNT, 64'd2);
        for (int i = 0; i < 32; i++) send(1'b0, 1'b0, 2'b00, 64'd0);

        // Lock acquisition with 64 data headers
        for (int i = 0; i < 63; i++) send(1'b1, 1'b0, 2'b01, pl(i));
        settle();
        check("lock_63", BLOCK_LOCK, 64'd0);
        send(1'b1, 1'b0, 2'b01, pl(63));
        settle();
        check("lock_64", BLOCK_LOCK, 64'd1);
        check("lock_64_slip", SLIP, 64'd0);
        check("lock_64_dv", DATA_VALID_OUT, 64'd0);
        send(1'b1, 1'b0, 2'b01, pl(100));
        settle();
        check("word65_dv", DATA_VALID_OUT, 64'd1);
        check("word65_data", DATA_OUT, pl(100));

        // Inverted control word
        send(1'b1, 1'b1, 2'b10, 64'hFFFF_0000_FFFF_0000);
        settle();
        check("inv_data", DATA_OUT, 64'h0000_FFFF_0000_FFFF);
        check("inv_hdr", HEADER_OUT, 64'd2);
        check("inv_herr", HEADER_ERR, 64'd0);
        for (int i = 0; i < 62; i++) send(1'b1, 1'b0, i[0] ? 2'b10 : 2'b01, pl(200 + i));

        // Window with 15 errors, the last on the window's final word
        for (int i = 0; i < 49; i++) send(1'b1, 1'b0, 2'b01, pl(300 + i));
        for (int i = 0; i < 15; i++) send(1'b1, 1'b0, 2'b11, pl(400 + i));
        settle();
        check("winA_lock", BLOCK_LOCK, 64'd1);
        check("winA_ec", ERR_COUNT, 64'd17);
        // Next window starts clean: 15 more errors keep lock
        for (int i = 0; i < 15; i++) send(1'b1, 1'b0, 2'b00, pl(500 + i));
        for (int i = 0; i < 49; i++) send(1'b1, 1'b0, 2'b10, pl(600 + i));
        settle();
        check("winB_lock", BLOCK_LOCK, 64'd1);
        check("winB_ec", ERR_COUNT, 64'd32);
        // 16 errors in one window lose lock
        for (int i = 0; i < 15; i++) send(1'b1, 1'b0, 2'b11, pl(700 + i));
        settle();
        check("err15_lock", BLOCK_LOCK, 64'd1);
        check("err15_ec", ERR_COUNT, 64'd47);
        send(1'b1, 1'b0, 2'b11, pl(715));
        settle();
        check("err16_lock", BLOCK_LOCK, 64'd0);
        check("err16_slip", SLIP, 64'd1);
        check("err16_dv", DATA_VALID_OUT, 64'd1);
        check("err16_ec", ERR_COUNT, 64'd48);
        for (int i = 0; i < 32; i++) send(1'b1, 1'b0, 2'b00, pl(800 + i));
        settle();
        check("wait2_ec", ERR_COUNT, 64'd48);

        // Relock through gaps; gaps must not advance the lock window
        for (int i = 0; i < 64; i++) begin
            send(1'b1, 1'b0, 2'b01, pl(900 + i));
            send(1'b0, 1'b0, 2'b11, 64'd0);
        end
        settle();
        check("gap_lock", BLOCK_LOCK, 64'd1);
        for (int i = 0; i < 10; i++) send(1'b1, 1'b0, 2'b00, pl(1000 + i));
        for (int i = 0; i < 20; i++) send(1'b0, 1'b0, 2'b00, 64'd0);
        for (int i = 0; i < 44; i++) send(1'b1, 1'b0, 2'b01, pl(1100 + i));
        for (int i = 0; i < 5; i++) send(1'b1, 1'b0, 2'b11, pl(1200 + i));
        settle();
        check("gap_err15_lock", BLOCK_LOCK, 64'd1);
        check("gap_err15_ec", ERR_COUNT, 64'd63);
        send(1'b1, 1'b0, 2'b11, pl(1205));
        settle();
        check("gap_err16_lock", BLOCK_LOCK, 64'd0);
        check("gap_err16_slip", SLIP, 64'd1);
        check("gap_err16_ec", ERR_COUNT, 64'd64);

        // Asynchronous reset in the middle of a locked window
        for (int i = 0; i < 32; i++) send(1'b0, 1'b0, 2'b00, 64'd0);
        for (int i = 0; i < 74; i++) send(1'b1, 1'b0, 2'b01, pl(1300 + i));
        settle();
        check("prereset_lock", BLOCK_LOCK, 64'd1);
        #4;
        SYSTEM_RESET = 1'b1;
        #1;
        check_all_zero("async_rst");
        DATA_VALID_IN = 1'b0;
        m_reset();
        repeat (2) @(posedge USER_CLK);
        @(negedge USER_CLK);
        SYSTEM_RESET = 1'b0;
        for (int i = 0; i < 63; i++) send(1'b1, 1'b0, 2'b10, pl(1400 + i));
        settle();
        check("relock_63", BLOCK_LOCK, 64'd0);
        send(1'b1, 1'b0, 2'b10, pl(1463));
        settle();
        check("relock_64", BLOCK_LOCK, 64'd1);

        // Passthrough: raw payload, no header checking, lock forced off
        PASSTHROUGH = 1'b1;
        send(1'b1, 1'b1, 2'b00, 64'h0123_4567_89AB_CDEF);
        settle();
        check("pt_data", DATA_OUT, 64'h0123_4567_89AB_CDEF);
        check("pt_hdr", HEADER_OUT, 64'd0);
        check("pt_herr", HEADER_ERR, 64'd0);
        check("pt_lock", BLOCK_LOCK, 64'd0);
        check("pt_dv", DATA_VALID_OUT, 64'd1);
        check("pt_ec", ERR_COUNT, 64'd0);
        send(1'b0, 1'b0, 2'b01, 64'd0);
        settle();
        check("pt_novalid", DATA_VALID_OUT, 64'd0);
        PASSTHROUGH = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b1, 1'b0, 2'b01, pl(1500 + i));
        settle();
        check("post_pt_lock", BLOCK_LOCK, 64'd0);
        check("post_pt_dv", DATA_VALID_OUT, 64'd0);
        settle();
        check("queue_drained", exp_q.size(), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_decode_64b_67b
